// File: rtl/exu_disp_ctrl_if.sv
// ---------------------------------------------------------------------------
// exu_disp_ctrl_if
//   Handshake bundle between the decoder, the dispatch controller and the
//   execution units (ALU, long pipe and its retire path).
//   Signal names keep their original i_/o_ prefixes as seen from the
//   dispatch controller.
//
//   slave  : dispatch controller side (consumes i_*, drives o_*)
//   master : decoder / execution-unit side (drives i_*, consumes o_*)
//
//   i_disp_valid/o_disp_ready        decoded instruction handshake
//   i_disp_long/illegal              steering and illegal flag
//   i_disp_rs1en/rs2en/rdwen         register enables
//   i_disp_rs1idx/rs2idx/rdidx       register indices
//   o_alu_valid/i_alu_ready          issue to 1-cycle ALU
//   o_long_valid/i_long_ready        issue to long pipe
//   o_long_itag                      OITF tag of the issued long op
//   i_ret_valid/i_ret_itag           long-pipe retire of its oldest op
// ---------------------------------------------------------------------------
interface exu_disp_ctrl_if #(
    parameter int unsigned ITAG_W      = 1,
    parameter int unsigned RFIDX_WIDTH = 5
);
    logic                   i_disp_valid;
    logic                   o_disp_ready;
    logic                   i_disp_long;
    logic                   i_disp_illegal;
    logic                   i_disp_rs1en;
    logic                   i_disp_rs2en;
    logic                   i_disp_rdwen;
    logic [RFIDX_WIDTH-1:0] i_disp_rs1idx;
    logic [RFIDX_WIDTH-1:0] i_disp_rs2idx;
    logic [RFIDX_WIDTH-1:0] i_disp_rdidx;
    logic                   o_alu_valid;
    logic                   i_alu_ready;
    logic                   o_long_valid;
    logic                   i_long_ready;
    logic [ITAG_W-1:0]      o_long_itag;
    logic                   i_ret_valid;
    logic [ITAG_W-1:0]      i_ret_itag;

    modport slave (
        input  i_disp_valid, i_disp_long, i_disp_illegal,
        input  i_disp_rs1en, i_disp_rs2en, i_disp_rdwen,
        input  i_disp_rs1idx, i_disp_rs2idx, i_disp_rdidx,
        input  i_alu_ready, i_long_ready, i_ret_valid, i_ret_itag,
        output o_disp_ready, o_alu_valid, o_long_valid, o_long_itag
    );

    modport master (
        output i_disp_valid, i_disp_long, i_disp_illegal,
        output i_disp_rs1en, i_disp_rs2en, i_disp_rdwen,
        output i_disp_rs1idx, i_disp_rs2idx, i_disp_rdidx,
        output i_alu_ready, i_long_ready, i_ret_valid, i_ret_itag,
        input  o_disp_ready, o_alu_valid, o_long_valid, o_long_itag
    );
endinterface

// File: rtl/exu_disp_ctrl.sv
// ---------------------------------------------------------------------------
// exu_disp_ctrl
//   Dispatch scheduler between decode and the execution units. Long-latency
//   ops (mul/div, load/store) are tracked in an in-order tracking FIFO
//   (OITF) of 2**ITAG_W entries. Decoded instructions stall on RAW/WAW
//   hazards against outstanding writebacks and are steered to the ALU or
//   the long pipe. Illegal instructions drain the OITF, then trap.
//
//   clk, rst_n     clock (rising) and asynchronous active-low reset
//   i_flush        pipeline flush, blocks dispatch this cycle
//   disp           exu_disp_ctrl_if.slave handshake bundle
//   o_oitf_empty   no outstanding long ops
//   o_trap         one-cycle illegal-instruction trap pulse
//   o_err          sticky retire protocol error
// ---------------------------------------------------------------------------
module exu_disp_ctrl #(
    parameter int unsigned ITAG_W      = 1,
    parameter int unsigned RFIDX_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    exu_disp_ctrl_if.slave       disp,
    output logic                 o_oitf_empty,
    output logic                 o_trap,
    output logic                 o_err
);
    localparam int unsigned DEPTH = 1 << ITAG_W;
    localparam logic [ITAG_W:0] PTR_ONE = {{ITAG_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ITAG_W:0]        r_wr_ptr;
    logic [ITAG_W:0]        r_rd_ptr;
    logic [DEPTH-1:0]       r_ent_vld;
    logic [DEPTH-1:0]       r_ent_rdwen;
    logic [RFIDX_WIDTH-1:0] r_ent_rdidx [DEPTH];
    logic                   r_err;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_hazard;
    logic                   w_go;
    logic                   w_alu_valid;
    logic                   w_long_valid;
    logic                   w_disp_ready;
    logic                   w_alloc;
    logic                   w_ret_do;
    logic                   w_ret_bad;
    logic [ITAG_W-1:0]      w_wr_idx;
    logic [ITAG_W-1:0]      w_rd_idx;

    assign w_wr_idx = r_wr_ptr[ITAG_W-1:0];
    assign w_rd_idx = r_rd_ptr[ITAG_W-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[ITAG_W] != r_rd_ptr[ITAG_W]) && (w_wr_idx == w_rd_idx);

    // Hazard check uses registered entries only, so an entry retiring this
    // cycle still blocks (no retire-to-dispatch bypass).
    always_comb begin
        w_hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_ent_vld[i] && r_ent_rdwen[i]) begin
                if ((disp.i_disp_rs1en && (disp.i_disp_rs1idx == r_ent_rdidx[i])) ||
                    (disp.i_disp_rs2en && (disp.i_disp_rs2idx == r_ent_rdidx[i])) ||
                    (disp.i_disp_rdwen && (disp.i_disp_rdidx  == r_ent_rdidx[i]))) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    // Next-state and dispatch outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_go         = 1'b0;
        w_alu_valid  = 1'b0;
        w_long_valid = 1'b0;
        w_disp_ready = 1'b0;

        w_go = disp.i_disp_valid && (r_state == ST_RUN) && !i_flush &&
               !disp.i_disp_illegal && !w_hazard;
        w_alu_valid  = w_go && !disp.i_disp_long;
        w_long_valid = w_go && disp.i_disp_long && !w_full;
        w_disp_ready = (w_alu_valid && disp.i_alu_ready) ||
                       (w_long_valid && disp.i_long_ready) ||
                       (r_state == ST_TRAP);

        case (r_state)
            ST_RUN: begin
                if (disp.i_disp_valid && disp.i_disp_illegal && !i_flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (i_flush) begin
                    w_state_nxt = ST_RUN;
                end else if (w_empty) begin
                    w_state_nxt = ST_TRAP;
                end
            end
            ST_TRAP: w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_alloc   = w_long_valid && disp.i_long_ready;
    assign w_ret_do  = disp.i_ret_valid && !w_empty;
    // Mismatched tag is flagged but the oldest entry is still retired.
    assign w_ret_bad = disp.i_ret_valid && (w_empty || (disp.i_ret_itag != w_rd_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Alloc and retire never hit the same slot: alloc needs not-full and
    // retire needs not-empty, so the slots differ whenever both fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ent_vld   <= '0;
            r_ent_rdwen <= '0;
            r_err       <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ent_rdidx[i] <= '0;
            end
        end else begin
            if (w_ret_do) begin
                r_ent_vld[w_rd_idx] <= 1'b0;
                r_rd_ptr            <= r_rd_ptr + PTR_ONE;
            end
            if (w_alloc) begin
                r_ent_vld[w_wr_idx]   <= 1'b1;
                r_ent_rdwen[w_wr_idx] <= disp.i_disp_rdwen;
                r_ent_rdidx[w_wr_idx] <= disp.i_disp_rdidx;
                r_wr_ptr              <= r_wr_ptr + PTR_ONE;
            end
            if (w_ret_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign disp.o_alu_valid  = w_alu_valid;
    assign disp.o_long_valid = w_long_valid;
    assign disp.o_disp_ready = w_disp_ready;
    assign disp.o_long_itag  = w_wr_idx;
    assign o_oitf_empty      = w_empty;
    assign o_trap            = (r_state == ST_TRAP);
    assign o_err             = r_err;
endmodule

// File: tb/tb_exu_disp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exu_disp_ctrl
//   Directed bench for exu_disp_ctrl. The stimulus process drives one
//   vector per cycle (#1 after the rising edge) and queues the expected
//   outputs for that cycle; the monitor samples on the falling edge and
//   compares against the queue.
// ---------------------------------------------------------------------------
module tb_exu_disp_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic i_flush;
    logic o_oitf_empty;
    logic o_trap;
    logic o_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [5:0] v;      // {alu, long, ready, trap, empty, err}
        logic [0:0] itag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    exu_disp_ctrl_if #(.ITAG_W(1), .RFIDX_WIDTH(5)) bus ();

    exu_disp_ctrl #(.ITAG_W(1), .RFIDX_WIDTH(5)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (i_flush),
        .disp         (bus.slave),
        .o_oitf_empty (o_oitf_empty),
        .o_trap       (o_trap),
        .o_err        (o_err)
    );

    task automatic idle();
        bus.i_disp_valid   = 1'b0;
        bus.i_disp_long    = 1'b0;
        bus.i_disp_illegal = 1'b0;
        bus.i_disp_rs1en   = 1'b0;
        bus.i_disp_rs2en   = 1'b0;
        bus.i_disp_rdwen   = 1'b0;
        bus.i_disp_rs1idx  = '0;
        bus.i_disp_rs2idx  = '0;
        bus.i_disp_rdidx   = '0;
        bus.i_ret_valid    = 1'b0;
        bus.i_ret_itag     = '0;
        i_flush            = 1'b0;
    endtask

    task automatic ins(input logic lng, input logic ill,
                       input logic r1en, input logic [4:0] r1,
                       input logic r2en, input logic [4:0] r2,
                       input logic wen,  input logic [4:0] rd);
        bus.i_disp_valid   = 1'b1;
        bus.i_disp_long    = lng;
        bus.i_disp_illegal = ill;
        bus.i_disp_rs1en   = r1en;
        bus.i_disp_rs1idx  = r1;
        bus.i_disp_rs2en   = r2en;
        bus.i_disp_rs2idx  = r2;
        bus.i_disp_rdwen   = wen;
        bus.i_disp_rdidx   = rd;
    endtask

    task automatic ret(input logic [0:0] tag);
        bus.i_ret_valid = 1'b1;
        bus.i_ret_itag  = tag;
    endtask

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic cyc(input string nm, input logic alu, input logic lng,
                       input logic [0:0] itag, input logic rdy, input logic trap,
                       input logic empty, input logic err);
        exp_t e;
        e.name = nm;
        e.v    = {alu, lng, rdy, trap, empty, err};
        e.itag = itag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            act = {bus.o_alu_valid, bus.o_long_valid, bus.o_disp_ready,
                   o_trap, o_oitf_empty, o_err};
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ((act !== e.v) || (e.v[4] && (bus.o_long_itag !== e.itag))) begin
                    errors++;
                    $display("FAIL %s: got alu/long/rdy/trap/empty/err=%b itag=%0d, expected %b itag=%0d",
                             e.name, act, bus.o_long_itag, e.v, e.itag);
                end
            end else if (bus.o_alu_valid || bus.o_long_valid) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got alu/long=%b%b, expected no issue",
                         bus.o_alu_valid, bus.o_long_valid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        bus.i_alu_ready  = 1'b1;
        bus.i_long_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 0, 0, 0, 0, 0, 1, 0);

        // add x3,x1,x2 to ALU
        rst_n = 1'b1;
        idle(); ins(0, 0, 1, 1, 1, 2, 1, 3);  cyc("t1_add_alu",       1, 0, 0, 1, 0, 1, 0);
        idle();                               cyc("t1_oitf_empty",    0, 0, 0, 0, 0, 1, 0);

        // mul x5 then RAW-dependent add x6,x5,x1
        idle(); ins(1, 0, 1, 1, 1, 2, 1, 5);  cyc("t2_mul_issue",     0, 1, 0, 1, 0, 1, 0);
        idle(); ins(0, 0, 1, 5, 1, 1, 1, 6);  cyc("t2_raw_stall",     0, 0, 0, 0, 0, 0, 0);
        idle(); ins(0, 0, 1, 5, 1, 1, 1, 6); ret(0);
                                              cyc("t2_stall_on_ret",  0, 0, 0, 0, 0, 0, 0);
        idle(); ins(0, 0, 1, 5, 1, 1, 1, 6);  cyc("t2_add_after_ret", 1, 0, 0, 1, 0, 1, 0);

        // fill OITF, block third, wrap to itag 0
        idle(); rst_n = 1'b0;                 cyc("t3_reset",         0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 7);  cyc("t3_long_a",        0, 1, 0, 1, 0, 1, 0);
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 8);  cyc("t3_long_b",        0, 1, 1, 1, 0, 0, 0);
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 9);  cyc("t3_full_block",    0, 0, 0, 0, 0, 0, 0);
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 9); ret(0);
                                              cyc("t3_full_with_ret", 0, 0, 0, 0, 0, 0, 0);
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 9);  cyc("t3_wrap_itag0",    0, 1, 0, 1, 0, 0, 0);
        idle(); ret(1);                       cyc("t3_ret_b",         0, 0, 0, 0, 0, 0, 0);
        idle(); ret(0);                       cyc("t3_ret_c",         0, 0, 0, 0, 0, 0, 0);

        // illegal with mul outstanding: drain then one-cycle trap
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 5);  cyc("t4_mul",           0, 1, 1, 1, 0, 1, 0);
        idle(); ins(0, 1, 0, 0, 0, 0, 0, 0);  cyc("t4_illegal_seen",  0, 0, 0, 0, 0, 0, 0);
        idle(); ins(0, 1, 0, 0, 0, 0, 0, 0);  cyc("t4_drain_wait",    0, 0, 0, 0, 0, 0, 0);
        idle(); ins(0, 1, 0, 0, 0, 0, 0, 0); ret(1);
                                              cyc("t4_drain_ret",     0, 0, 0, 0, 0, 0, 0);
        idle(); ins(0, 1, 0, 0, 0, 0, 0, 0);  cyc("t4_drain_empty",   0, 0, 0, 0, 0, 1, 0);
        idle(); ins(0, 1, 0, 0, 0, 0, 0, 0);  cyc("t4_trap",          0, 0, 0, 1, 1, 1, 0);
        idle();                               cyc("t4_trap_one_cyc",  0, 0, 0, 0, 0, 1, 0);

        // protocol errors
        idle(); ret(0);                       cyc("t5_ret_empty",     0, 0, 0, 0, 0, 1, 0);
        idle();                               cyc("t5_err_set",       0, 0, 0, 0, 0, 1, 1);
        idle();                               cyc("t5_err_sticky",    0, 0, 0, 0, 0, 1, 1);
        idle(); rst_n = 1'b0;                 cyc("t5_reset_err",     0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 10); cyc("t5_long",          0, 1, 0, 1, 0, 1, 0);
        idle(); ret(1);                       cyc("t5_bad_tag",       0, 0, 0, 0, 0, 0, 0);
        idle();                               cyc("t5_bad_tag_err",   0, 0, 0, 0, 0, 1, 1);
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 11); cyc("t5_ptr_advanced",  0, 1, 1, 1, 0, 1, 1);

        // async reset in DRAIN with two entries
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 12); cyc("t6_second_long",   0, 1, 0, 1, 0, 0, 1);
        idle(); ins(0, 1, 0, 0, 0, 0, 0, 0);  cyc("t6_illegal",       0, 0, 0, 0, 0, 0, 1);
        idle();                               cyc("t6_draining",      0, 0, 0, 0, 0, 0, 1);
        idle(); rst_n = 1'b0;                 cyc("t6_async_reset",   0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        idle(); ins(0, 0, 1, 11, 1, 12, 1, 12);
                                              cyc("t6_run_no_hazard", 1, 0, 0, 1, 0, 1, 0);

        // flush abandons DRAIN and blocks dispatch; ALU backpressure
        idle(); ins(1, 0, 0, 0, 0, 0, 1, 13); cyc("t7_long",          0, 1, 0, 1, 0, 1, 0);
        idle(); ins(0, 1, 0, 0, 0, 0, 0, 0);  cyc("t7_illegal",       0, 0, 0, 0, 0, 0, 0);
        idle(); ins(0, 1, 0, 0, 0, 0, 0, 0); i_flush = 1'b1;
                                              cyc("t7_flush_drain",   0, 0, 0, 0, 0, 0, 0);
        idle(); ins(0, 0, 1, 1, 1, 2, 1, 3);  cyc("t7_back_in_run",   1, 0, 0, 1, 0, 0, 0);
        idle(); ins(0, 0, 1, 1, 1, 2, 1, 3); i_flush = 1'b1;
                                              cyc("t7_flush_blocks",  0, 0, 0, 0, 0, 0, 0);
        idle(); ins(0, 0, 1, 1, 1, 2, 1, 3); bus.i_alu_ready = 1'b0;
                                              cyc("t7_alu_bp",        1, 0, 0, 0, 0, 0, 0);
        bus.i_alu_ready = 1'b1;
        idle(); ret(0);                       cyc("t7_ret",           0, 0, 0, 0, 0, 0, 0);
        idle();                               cyc("t7_final_empty",   0, 0, 0, 0, 0, 1, 0);

        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
